// File: rtl/pe_pkg.sv
// Shared types and saturation limits for the SIMD MAC processing element.
package pe_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    ARMED = 1'b1
  } pe_state_e;

  // Largest positive value representable in a w-bit signed word.
  function automatic logic signed [127:0] sat_max(input int unsigned w);
    return (128'sd1 <<< (w - 1)) - 128'sd1;
  endfunction

  // Most negative value representable in a w-bit signed word.
  function automatic logic signed [127:0] sat_min(input int unsigned w);
    return -(128'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/pe_lane_mac.sv
// One MAC lane: signed multiply, add to incoming partial sum, saturate.
// Purely combinational; the top registers the result.
module pe_lane_mac
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int PSUM_WIDTH = 32
) (
  input  logic signed [DATA_WIDTH-1:0] stat_i,
  input  logic signed [DATA_WIDTH-1:0] strm_i,
  input  logic signed [PSUM_WIDTH-1:0] psum_i,
  output logic signed [PSUM_WIDTH-1:0] sum_o,
  output logic                         ovf_o
);

  localparam logic signed [PSUM_WIDTH-1:0] SMAX = PSUM_WIDTH'(sat_max(PSUM_WIDTH));
  localparam logic signed [PSUM_WIDTH-1:0] SMIN = PSUM_WIDTH'(sat_min(PSUM_WIDTH));

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [PSUM_WIDTH:0]     sum;

  // One guard bit is enough: a product plus a psum cannot exceed twice the psum range.
  always_comb begin
    prod  = stat_i * strm_i;
    sum   = (PSUM_WIDTH+1)'(psum_i) + (PSUM_WIDTH+1)'(prod);
    ovf_o = sum[PSUM_WIDTH] != sum[PSUM_WIDTH-1];
    if (ovf_o) sum_o = sum[PSUM_WIDTH] ? SMIN : SMAX;
    else       sum_o = sum[PSUM_WIDTH-1:0];
  end

endmodule

// File: rtl/pe_simd_mac.sv
// Multi-lane counted stationary-operand MAC PE for the systolic array.
// Optional feature macro PE_SHADOW_EN adds a shadow stationary register so a
// new operand set can be queued while the current one is still counting.
module pe_simd_mac
  import pe_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 16,
  parameter int PSUM_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [LANES*DATA_WIDTH-1:0]   load_data,
  input  logic [CNT_WIDTH-1:0]          load_count,
  input  logic                          stream_valid_in,
  input  logic [LANES*DATA_WIDTH-1:0]   stream_in,
  input  logic                          psum_valid_in,
  input  logic [LANES*PSUM_WIDTH-1:0]   psum_in,
  output logic                          stream_valid_out,
  output logic [LANES*DATA_WIDTH-1:0]   stream_out,
  output logic                          psum_valid_out,
  output logic [LANES*PSUM_WIDTH-1:0]   psum_out,
  output logic                          armed,
  output logic [LANES-1:0]              sat_flag,
  output logic                          protocol_err
);

  typedef logic [LANES-1:0][DATA_WIDTH-1:0] dvec_t;
  typedef logic [LANES-1:0][PSUM_WIDTH-1:0] pvec_t;

  dvec_t ld, strm, act_q, act_d;
  pvec_t ps, mac;
  logic [LANES-1:0] ovf;

  pe_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0] rem_q, rem_d;

`ifdef PE_SHADOW_EN
  dvec_t                shd_q, shd_d;
  logic [CNT_WIDTH-1:0] shd_cnt_q, shd_cnt_d;
  logic                 shd_v_q, shd_v_d;
`endif

  pvec_t            psum_q;
  dvec_t            strm_q;
  logic             pv_q, sv_q, perr_q;
  logic [LANES-1:0] sat_q;

  logic fire, expire, load_acc;

  assign ld   = load_data;
  assign strm = stream_in;
  assign ps   = psum_in;

`ifdef PE_SHADOW_EN
  assign load_ready = !clear && (state_q == EMPTY || !shd_v_q);
`else
  assign load_ready = !clear && (state_q == EMPTY);
`endif

  assign load_acc = load_valid && load_ready;
  assign fire     = (state_q == ARMED) && stream_valid_in && psum_valid_in;
  assign expire   = fire && (rem_q == CNT_WIDTH'(1));

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    pe_lane_mac #(
      .DATA_WIDTH (DATA_WIDTH),
      .PSUM_WIDTH (PSUM_WIDTH)
    ) u_lane (
      .stat_i (act_q[g]),
      .strm_i (strm[g]),
      .psum_i (ps[g]),
      .sum_o  (mac[g]),
      .ovf_o  (ovf[g])
    );
  end

  // Operand state: load, count down, expire, and (optionally) promote the shadow.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    act_d   = act_q;
`ifdef PE_SHADOW_EN
    shd_d     = shd_q;
    shd_cnt_d = shd_cnt_q;
    shd_v_d   = shd_v_q;
`endif
    if (clear) begin
      state_d = EMPTY;
`ifdef PE_SHADOW_EN
      shd_v_d = 1'b0;
`endif
    end else if (expire) begin
`ifdef PE_SHADOW_EN
      if (shd_v_q) begin
        act_d   = shd_q;
        rem_d   = shd_cnt_q;
        shd_v_d = 1'b0;
      end else if (load_acc) begin
        act_d = ld;
        rem_d = load_count;
      end else begin
        state_d = EMPTY;
      end
`else
      state_d = EMPTY;
`endif
    end else begin
      if (fire && rem_q != '0) rem_d = rem_q - CNT_WIDTH'(1);
      if (load_acc) begin
        if (state_q == EMPTY) begin
          state_d = ARMED;
          act_d   = ld;
          rem_d   = load_count;
        end
`ifdef PE_SHADOW_EN
        else begin
          shd_d     = ld;
          shd_cnt_d = load_count;
          shd_v_d   = 1'b1;
        end
`endif
      end
    end
  end

  // Operand state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      rem_q   <= '0;
      act_q   <= '0;
`ifdef PE_SHADOW_EN
      shd_q     <= '0;
      shd_cnt_q <= '0;
      shd_v_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      act_q   <= act_d;
`ifdef PE_SHADOW_EN
      shd_q     <= shd_d;
      shd_cnt_q <= shd_cnt_d;
      shd_v_q   <= shd_v_d;
`endif
    end
  end

  // Registered forward paths and sticky flags; data holds when its valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psum_q <= '0;
      strm_q <= '0;
      pv_q   <= 1'b0;
      sv_q   <= 1'b0;
      sat_q  <= '0;
      perr_q <= 1'b0;
    end else if (clear) begin
      pv_q   <= 1'b0;
      sv_q   <= 1'b0;
      sat_q  <= '0;
      perr_q <= 1'b0;
    end else begin
      pv_q <= psum_valid_in;
      sv_q <= stream_valid_in;
      if (psum_valid_in)   psum_q <= fire ? mac : ps;
      if (stream_valid_in) strm_q <= strm;
      if (fire)            sat_q  <= sat_q | ovf;
      if (state_q == ARMED && (psum_valid_in != stream_valid_in)) perr_q <= 1'b1;
    end
  end

  assign psum_out         = psum_q;
  assign psum_valid_out   = pv_q;
  assign stream_out       = strm_q;
  assign stream_valid_out = sv_q;
  assign armed            = (state_q == ARMED);
  assign sat_flag         = sat_q;
  assign protocol_err     = perr_q;

endmodule

// File: tb/tb_pe_simd_mac.sv
// Self-checking bench for pe_simd_mac: queue-based operand model plus directed
// vectors with literal expectations, then a short randomized stretch.
module tb_pe_simd_mac;

  localparam int LANES = 4;
  localparam int DW    = 16;
  localparam int PW    = 32;
  localparam int CW    = 8;
`ifdef PE_SHADOW_EN
  localparam bit SHD = 1'b1;
`else
  localparam bit SHD = 1'b0;
`endif

  logic                  clk = 1'b0, rst = 1'b1, clear = 1'b0;
  logic                  load_valid = 1'b0, load_ready;
  logic [LANES*DW-1:0]   load_data = '0;
  logic [CW-1:0]         load_count = '0;
  logic                  stream_valid_in = 1'b0, psum_valid_in = 1'b0;
  logic [LANES*DW-1:0]   stream_in = '0;
  logic [LANES*PW-1:0]   psum_in = '0;
  logic                  stream_valid_out, psum_valid_out, armed, protocol_err;
  logic [LANES*DW-1:0]   stream_out;
  logic [LANES*PW-1:0]   psum_out;
  logic [LANES-1:0]      sat_flag;

  pe_simd_mac #(.LANES(LANES), .DATA_WIDTH(DW), .PSUM_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data), .load_count(load_count),
    .stream_valid_in(stream_valid_in), .stream_in(stream_in),
    .psum_valid_in(psum_valid_in), .psum_in(psum_in),
    .stream_valid_out(stream_valid_out), .stream_out(stream_out),
    .psum_valid_out(psum_valid_out), .psum_out(psum_out),
    .armed(armed), .sat_flag(sat_flag), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: loaded operand sets waiting or in use, front entry is the active one.
  typedef struct {
    logic [LANES*DW-1:0] data;
    int                  cnt;
  } ld_t;

  ld_t                 mq[$];
  logic [LANES*PW-1:0] m_psum = '0;
  logic [LANES*DW-1:0] m_strm = '0;
  bit                  m_pv = 0, m_sv = 0, m_perr = 0;
  logic [LANES-1:0]    m_sat = '0;

  localparam longint MAXV = (64'sd1 <<< (PW - 1)) - 64'sd1;
  localparam longint MINV = -(64'sd1 <<< (PW - 1));

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_psum = '0; m_strm = '0; m_pv = 0; m_sv = 0; m_perr = 0; m_sat = '0;
    end else if (clear) begin
      mq.delete();
      m_pv = 0; m_sv = 0; m_perr = 0; m_sat = '0;
    end else begin : mdl
      bit     rdy, act_now, fire;
      longint s, a, b;
      rdy     = (mq.size() == 0) || (SHD && mq.size() < 2);
      act_now = mq.size() > 0;
      fire    = act_now && stream_valid_in && psum_valid_in;
      if (psum_valid_in) begin
        for (int i = 0; i < LANES; i++) begin
          s = $signed(psum_in[i*PW +: PW]);
          if (fire) begin
            a = $signed(mq[0].data[i*DW +: DW]);
            b = $signed(stream_in[i*DW +: DW]);
            s = s + a * b;
            if (s > MAXV) begin s = MAXV; m_sat[i] = 1'b1; end
            if (s < MINV) begin s = MINV; m_sat[i] = 1'b1; end
          end
          m_psum[i*PW +: PW] = s[PW-1:0];
        end
      end
      m_pv = psum_valid_in;
      if (stream_valid_in) m_strm = stream_in;
      m_sv = stream_valid_in;
      if (act_now && (stream_valid_in != psum_valid_in)) m_perr = 1;
      if (fire) begin
        if (mq[0].cnt == 1) void'(mq.pop_front());
        else if (mq[0].cnt != 0) mq[0].cnt--;
      end
      if (load_valid && rdy) mq.push_back('{load_data, int'(load_count)});
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("psum_valid_out", psum_valid_out, m_pv);
    chk("psum_out", psum_out, m_psum);
    chk("stream_valid_out", stream_valid_out, m_sv);
    chk("stream_out", stream_out, m_strm);
    chk("armed", armed, mq.size() > 0);
    chk("sat_flag", sat_flag, m_sat);
    chk("protocol_err", protocol_err, m_perr);
    chk("load_ready", load_ready, !clear && (mq.size() == 0 || (SHD && mq.size() < 2)));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stream_valid_in = 0; psum_valid_in = 0; load_valid = 0; clear = 0;
  endtask

  initial begin
    step(); step();
    chk("rst psum_out", psum_out, '0);
    chk("rst load_ready", load_ready, 1);
    chk("rst armed", armed, 0);
    chk("rst flags", {sat_flag, protocol_err, psum_valid_out, stream_valid_out}, '0);
    rst = 0;

    // Counted load of two operations.
    load_data = '0; load_data[15:0] = 16'd3; load_data[31:16] = 16'hFFFE;
    load_count = 8'd2; load_valid = 1;
    step(); load_valid = 0;
    chk("t1 armed", armed, 1);
    stream_in = '0; stream_in[15:0] = 16'd5; stream_in[31:16] = 16'd7;
    psum_in = '0; psum_in[31:0] = 32'd10; psum_in[63:32] = 32'd100;
    stream_valid_in = 1; psum_valid_in = 1;
    step();
    chk("t1 fire1 lane0", psum_out[31:0], 32'd25);
    chk("t1 fire1 lane1", psum_out[63:32], 32'd86);
    chk("t1 still armed", armed, 1);
    step();
    chk("t1 fire2 lane0", psum_out[31:0], 32'd25);
    chk("t1 expired", armed, 0);
    chk("t1 load_ready", load_ready, 1);
    idle(); step();
    chk("t1 valid drop", psum_valid_out, 0);

    // Positive saturation on lane 0 only.
    load_data = {4{16'h7FFF}}; load_count = 8'd0; load_valid = 1;
    step(); load_valid = 0;
    stream_in = {4{16'h7FFF}}; psum_in = {32'h0, 32'h0, 32'h0, 32'h7FFFFFFF};
    stream_valid_in = 1; psum_valid_in = 1;
    step();
    chk("sat+ lane0", psum_out[31:0], 32'h7FFFFFFF);
    chk("sat+ lane1", psum_out[63:32], 32'h3FFF0001);
    chk("sat+ flag", sat_flag, 4'b0001);
    idle(); clear = 1;
    step(); clear = 0;
    chk("clear armed", armed, 0);
    chk("clear sat", sat_flag, 4'b0000);
    chk("clear data holds", psum_out[31:0], 32'h7FFFFFFF);

    // Negative saturation.
    load_data = '0; load_data[15:0] = 16'hFFFF; load_count = 8'd1; load_valid = 1;
    step(); load_valid = 0;
    stream_in = '0; stream_in[15:0] = 16'd1; psum_in = '0; psum_in[31:0] = 32'h80000000;
    stream_valid_in = 1; psum_valid_in = 1;
    step();
    chk("sat- lane0", psum_out[31:0], 32'h80000000);
    chk("sat- flag", sat_flag, 4'b0001);
    chk("sat- expired", armed, 0);

    // Bypass while EMPTY.
    psum_in = '0; psum_in[31:0] = 32'h1234; stream_in = '0; stream_in[15:0] = 16'hABCD;
    step();
    chk("bypass psum", psum_out[31:0], 32'h1234);
    chk("bypass stream", stream_out[15:0], 16'hABCD);
    chk("bypass no perr", protocol_err, 0);

    // Protocol error: stream without psum does not consume a count.
    idle();
    load_data = '0; load_data[15:0] = 16'd2; load_count = 8'd3; load_valid = 1;
    step(); load_valid = 0;
    stream_in = '0; stream_in[15:0] = 16'd4; stream_valid_in = 1;
    step();
    chk("perr set", protocol_err, 1);
    chk("perr no psum valid", psum_valid_out, 0);
    psum_in = '0; psum_in[31:0] = 32'd1; psum_valid_in = 1;
    step();
    chk("perr fire1", psum_out[31:0], 32'd9);
    step();
    chk("perr armed after 2", armed, 1);
    step();
    chk("perr expired after 3", armed, 0);
    idle(); clear = 1; step(); clear = 0;
    chk("perr cleared", protocol_err, 0);

    // clear beats load and fire in the same cycle.
    load_data = '0; load_data[15:0] = 16'd1; load_count = 8'd0; load_valid = 1;
    step();
    clear = 1; stream_valid_in = 1; psum_valid_in = 1; #1;
    chk("clr load_ready", load_ready, 0);
    step();
    chk("clr armed", armed, 0);
    chk("clr valids", {psum_valid_out, stream_valid_out}, 2'b00);
    idle(); step();
    chk("clr load dropped", armed, 0);

`ifdef PE_SHADOW_EN
    // Shadow: B queued behind A, promoted on A's expiry with no bubble.
    load_data = '0; load_data[15:0] = 16'd2; load_count = 8'd1; load_valid = 1;
    step();
    load_data[15:0] = 16'd3; load_count = 8'd0; #1;
    chk("shd ready", load_ready, 1);
    step(); load_valid = 0; #1;
    chk("shd full", load_ready, 0);
    stream_in = '0; stream_in[15:0] = 16'd1; psum_in = '0;
    stream_valid_in = 1; psum_valid_in = 1;
    step();
    chk("shd use A", psum_out[31:0], 32'd2);
    chk("shd no bubble", armed, 1);
    step();
    chk("shd use B", psum_out[31:0], 32'd3);
    step(); step();
    chk("shd B infinite", armed, 1);
`else
    // Without shadow a load while ARMED is refused.
    load_data = '0; load_data[15:0] = 16'd2; load_count = 8'd0; load_valid = 1;
    step();
    load_data[15:0] = 16'd9; #1;
    chk("noshd ready", load_ready, 0);
    step(); load_valid = 0;
    stream_in = '0; stream_in[15:0] = 16'd1; psum_in = '0;
    stream_valid_in = 1; psum_valid_in = 1;
    step();
    chk("noshd kept A", psum_out[31:0], 32'd2);
`endif
    idle(); clear = 1; step(); clear = 0;

    // Mixed traffic checked by the model only.
    for (int i = 0; i < 80; i++) begin
      load_valid      = ($urandom_range(0, 3) == 0);
      load_count      = CW'($urandom_range(0, 3));
      load_data       = {$urandom, $urandom};
      stream_valid_in = ($urandom_range(0, 3) != 0);
      psum_valid_in   = ($urandom_range(0, 3) != 0);
      stream_in       = {$urandom, $urandom};
      psum_in         = {$urandom, $urandom, $urandom, $urandom};
      clear           = ($urandom_range(0, 15) == 0);
      step();
    end
    idle();

    // Asynchronous reset mid-operation.
    load_data = '0; load_data[15:0] = 16'd5; load_count = 8'd0; load_valid = 1;
    step(); load_valid = 0; stream_valid_in = 1; psum_valid_in = 1;
    step();
    #2 rst = 1; #1;
    chk("async rst armed", armed, 0);
    chk("async rst valid", psum_valid_out, 0);
    chk("async rst psum", psum_out, '0);
    idle(); step(); rst = 0; step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
